// File: rtl/fdd_pkg.sv
// Shared types and constants for the floppy controller blocks.
package fdd_pkg;

    // Head-positioning sequencer states.
    typedef enum logic [2:0] {
        S_IDLE,
        S_DIRSET,
        S_STEP_HI,
        S_STEP_LO,
        S_SETTLE,
        S_DONE
    } fdd_state_t;

    // Error codes as reported by the ROM driver.
    localparam logic [6:0] ERR_NONE = 7'o0;
    localparam logic [6:0] ERR_TR0  = 7'o7;   // track 0 not found
    localparam logic [6:0] ERR_TRK  = 7'o10;  // requested track >= 128

endpackage

// File: rtl/fdd_seek_ctrl_if.sv
// Command/status bus between the PPU register decoder and the seek controller.
interface fdd_seek_ctrl_if;

    logic       cmd_seek;
    logic       cmd_recal;
    logic [7:0] target_i;
    logic       busy_o;
    logic       done_o;
    logic       err_o;
    logic [6:0] err_code_o;
    logic [7:0] cur_track_o;

    // Register decoder side: issues commands, observes status.
    modport master (
        output cmd_seek, cmd_recal, target_i,
        input  busy_o, done_o, err_o, err_code_o, cur_track_o
    );

    // Seek controller side.
    modport slave (
        input  cmd_seek, cmd_recal, target_i,
        output busy_o, done_o, err_o, err_code_o, cur_track_o
    );

endinterface

// File: rtl/fdd_seek_ctrl_sync2.sv
// Two-flop synchroniser for the asynchronous drive track-0 sensor.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Double-register the async input; both stages cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fdd_seek_ctrl.sv
// Floppy head-positioning sequencer: hardware seek and recalibrate with
// timed step/dir pulses, cylinder tracking and ROM-compatible error codes.
module fdd_seek_ctrl
    import fdd_pkg::*;
#(
    parameter int unsigned STEP_W    = 8,
    parameter int unsigned STEP_RATE = 75000,
    parameter int unsigned DIR_SETUP = 25,
    parameter int unsigned SETTLE    = 375000,
    parameter int unsigned MAX_RECAL = 84,
    parameter int unsigned CNT_W     = 20
) (
    input  logic            clk_25,
    input  logic            init_n,
    fdd_seek_ctrl_if.slave  bus,
    input  logic            tr0_i,
    output logic            step_o,
    output logic            dir_o
);

    localparam int unsigned RC_W = $clog2(MAX_RECAL + 1);

    // Reload values: a state lasts (load + 1) cycles before its exit edge.
    localparam logic [CNT_W-1:0] DIR_LD = CNT_W'(DIR_SETUP - 1);
    localparam logic [CNT_W-1:0] HI_LD  = CNT_W'(STEP_W - 1);
    localparam logic [CNT_W-1:0] LO_LD  = CNT_W'(STEP_RATE - STEP_W - 1);
    localparam logic [CNT_W-1:0] SET_LD = CNT_W'(SETTLE - 1);
    localparam logic [RC_W-1:0]  RC_MAX = RC_W'(MAX_RECAL);

    if (STEP_W < 1 || DIR_SETUP < 1 || SETTLE < 1 || MAX_RECAL < 1 ||
        STEP_RATE <= STEP_W ||
        64'(STEP_RATE) >= (64'd1 << CNT_W) ||
        64'(SETTLE)    >= (64'd1 << CNT_W) ||
        64'(DIR_SETUP) >= (64'd1 << CNT_W)) begin : g_param_range
        $error("fdd_seek_ctrl: timing parameter out of range for CNT_W");
    end

    fdd_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             is_recal;
    logic [7:0]       tgt;
    logic [7:0]       cur_q;
    logic [RC_W-1:0]  nsteps;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [6:0]       err_code_q;
    logic             tr0_s;

    sync2 u_tr0_sync (
        .clk   (clk_25),
        .rst_n (init_n),
        .d     (tr0_i),
        .q     (tr0_s)
    );

    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;
    assign bus.err_code_o  = err_code_q;
    assign bus.cur_track_o = cur_q;

    // Command acceptance, step timing and cylinder tracking in one FSM.
    always_ff @(posedge clk_25 or negedge init_n) begin
        if (!init_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            is_recal   <= 1'b0;
            tgt        <= '0;
            cur_q      <= '0;
            nsteps     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            step_o     <= 1'b0;
            dir_o      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.cmd_recal) begin
                        busy_q     <= 1'b1;
                        err_q      <= 1'b0;
                        err_code_q <= ERR_NONE;
                        is_recal   <= 1'b1;
                        nsteps     <= '0;
                        dir_o      <= 1'b0;
                        cnt        <= DIR_LD;
                        state      <= S_DIRSET;
                    end else if (bus.cmd_seek) begin
                        busy_q     <= 1'b1;
                        err_q      <= 1'b0;
                        err_code_q <= ERR_NONE;
                        is_recal   <= 1'b0;
                        tgt        <= bus.target_i;
                        if (bus.target_i[7]) begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_TRK;
                            cnt        <= '0;
                            state      <= S_DONE;
                        end else if (bus.target_i == cur_q) begin
                            cnt   <= '0;
                            state <= S_DONE;
                        end else begin
                            dir_o <= (bus.target_i > cur_q);
                            cnt   <= DIR_LD;
                            state <= S_DIRSET;
                        end
                    end
                end

                // Both states end in the same "issue next step" decision, so
                // the recal tr0 and retry-limit checks live in one place.
                S_DIRSET, S_STEP_LO: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (is_recal && tr0_s) begin
                        cur_q <= '0;
                        cnt   <= SET_LD;
                        state <= S_SETTLE;
                    end else if (is_recal && nsteps == RC_MAX) begin
                        cur_q      <= '0;
                        err_q      <= 1'b1;
                        err_code_q <= ERR_TR0;
                        cnt        <= '0;
                        state      <= S_DONE;
                    end else begin
                        step_o <= 1'b1;
                        cnt    <= HI_LD;
                        state  <= S_STEP_HI;
                        if (is_recal) begin
                            nsteps <= nsteps + 1'b1;
                            cur_q  <= (cur_q == '0) ? '0 : cur_q - 8'd1;
                        end else begin
                            cur_q  <= dir_o ? cur_q + 8'd1 : cur_q - 8'd1;
                        end
                    end
                end

                S_STEP_HI: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        step_o <= 1'b0;
                        if (!is_recal && cur_q == tgt) begin
                            cnt   <= SET_LD;
                            state <= S_SETTLE;
                        end else begin
                            cnt   <= LO_LD;
                            state <= S_STEP_LO;
                        end
                    end
                end

                S_SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        cnt   <= '0;
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    cnt    <= '0;
                    state  <= S_IDLE;
                end

                default: begin
                    step_o <= 1'b0;
                    busy_q <= 1'b0;
                    cnt    <= '0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fdd_seek_ctrl.sv
// Directed bench for fdd_seek_ctrl with shortened timing parameters.
module tb_fdd_seek_ctrl;
    import fdd_pkg::*;

    localparam int P_STEP_W    = 2;
    localparam int P_STEP_RATE = 10;
    localparam int P_DIR_SETUP = 3;
    localparam int P_SETTLE    = 20;
    localparam int P_MAX_RECAL = 5;

    logic clk    = 1'b0;
    logic init_n = 1'b0;
    logic tr0_i  = 1'b0;
    logic step_o;
    logic dir_o;

    fdd_seek_ctrl_if bus ();

    fdd_seek_ctrl #(
        .STEP_W    (P_STEP_W),
        .STEP_RATE (P_STEP_RATE),
        .DIR_SETUP (P_DIR_SETUP),
        .SETTLE    (P_SETTLE),
        .MAX_RECAL (P_MAX_RECAL),
        .CNT_W     (20)
    ) dut (
        .clk_25 (clk),
        .init_n (init_n),
        .bus    (bus),
        .tr0_i  (tr0_i),
        .step_o (step_o),
        .dir_o  (dir_o)
    );

    always #5 clk = ~clk;

    // Edge index: at a falling edge, cyc is the number of the last rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Step pulse monitor.
    int   n_rise = 0;
    int   rise_cyc    [0:63];
    int   cur_at_rise [0:63];
    int   width       [0:63];
    logic step_prev = 1'b0;
    always @(negedge clk) begin
        if (step_o && !step_prev) begin
            rise_cyc[n_rise]    = cyc;
            cur_at_rise[n_rise] = int'(bus.cur_track_o);
            n_rise              = n_rise + 1;
        end
        if (!step_o && step_prev && n_rise > 0)
            width[n_rise-1] = cyc - rise_cyc[n_rise-1];
        step_prev = step_o;
    end

    int   n_checks = 0;
    int   n_fail   = 0;
    int   acc;
    int   dcyc;
    int   base;
    logic busy_at_done;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic issue_seek(input logic [7:0] t);
        @(negedge clk);
        bus.target_i = t;
        bus.cmd_seek = 1'b1;
        @(negedge clk);
        bus.cmd_seek = 1'b0;
        acc = cyc;
    endtask

    task automatic issue_recal();
        @(negedge clk);
        bus.cmd_recal = 1'b1;
        @(negedge clk);
        bus.cmd_recal = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_done(input int budget);
        dcyc = -1;
        busy_at_done = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (bus.done_o) begin
                dcyc = cyc;
                busy_at_done = bus.busy_o;
                break;
            end
            @(negedge clk);
        end
        check_eq("done_seen", (dcyc >= 0), 1);
    endtask

    initial begin
        bus.cmd_seek  = 1'b0;
        bus.cmd_recal = 1'b0;
        bus.target_i  = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_step",  step_o, 0);
        check_eq("rst_dir",   dir_o, 0);
        check_eq("rst_busy",  bus.busy_o, 0);
        check_eq("rst_done",  bus.done_o, 0);
        check_eq("rst_err",   bus.err_o, 0);
        check_eq("rst_code",  bus.err_code_o, 0);
        check_eq("rst_track", bus.cur_track_o, 0);
        init_n = 1'b1;
        repeat (2) @(negedge clk);

        // Seek 0 -> 3
        base = n_rise;
        issue_seek(8'd3);
        check_eq("t1_dir",  dir_o, 1);
        check_eq("t1_busy", bus.busy_o, 1);
        wait_done(300);
        check_eq("t1_pulses", n_rise - base, 3);
        check_eq("t1_first_rise", rise_cyc[base] - acc, P_DIR_SETUP);
        for (int i = 0; i < 3; i++) begin
            check_eq("t1_width", width[base+i], P_STEP_W);
            check_eq("t1_track_at_step", cur_at_rise[base+i], i + 1);
        end
        for (int i = 1; i < 3; i++)
            check_eq("t1_rate", rise_cyc[base+i] - rise_cyc[base+i-1], P_STEP_RATE);
        // settle starts as the last pulse falls; one more edge for done
        check_eq("t1_done_lat", dcyc - rise_cyc[base+2], P_STEP_W + P_SETTLE + 1);
        check_eq("t1_busy_at_done", busy_at_done, 0);
        check_eq("t1_track", bus.cur_track_o, 3);
        check_eq("t1_err", bus.err_o, 0);

        // Seek 3 -> 1
        base = n_rise;
        issue_seek(8'd1);
        check_eq("t2_dir", dir_o, 0);
        wait_done(300);
        check_eq("t2_pulses", n_rise - base, 2);
        check_eq("t2_track_at_step0", cur_at_rise[base], 2);
        check_eq("t2_track_at_step1", cur_at_rise[base+1], 1);
        check_eq("t2_done_lat", dcyc - rise_cyc[base+1], P_STEP_W + P_SETTLE + 1);
        check_eq("t2_track", bus.cur_track_o, 1);
        check_eq("t2_err", bus.err_o, 0);

        // Recal from track 1, tr0 rises after the second step
        base = n_rise;
        issue_recal();
        check_eq("t3_dir", dir_o, 0);
        for (int i = 0; i < 100 && n_rise < base + 2; i++) @(negedge clk);
        check_eq("t3_two_steps_seen", (n_rise >= base + 2), 1);
        tr0_i = 1'b1;
        wait_done(300);
        check_eq("t3_pulses", n_rise - base, 2);
        check_eq("t3_track_sat", cur_at_rise[base+1], 0);
        check_eq("t3_done_lat", dcyc - rise_cyc[base+1], P_STEP_RATE + P_SETTLE + 1);
        check_eq("t3_track", bus.cur_track_o, 0);
        check_eq("t3_err", bus.err_o, 0);
        tr0_i = 1'b0;
        repeat (4) @(negedge clk);

        // Recal with tr0 never asserting
        base = n_rise;
        issue_recal();
        wait_done(400);
        check_eq("t4_pulses", n_rise - base, P_MAX_RECAL);
        check_eq("t4_done_lat", dcyc - rise_cyc[base+P_MAX_RECAL-1], P_STEP_RATE + 1);
        check_eq("t4_err", bus.err_o, 1);
        check_eq("t4_code", bus.err_code_o, 7'o7);
        check_eq("t4_track", bus.cur_track_o, 0);

        // Recal with tr0 already high: no steps, settle only
        tr0_i = 1'b1;
        repeat (4) @(negedge clk);
        base = n_rise;
        issue_recal();
        wait_done(200);
        check_eq("t4b_pulses", n_rise - base, 0);
        check_eq("t4b_done_lat", dcyc - acc, P_DIR_SETUP + P_SETTLE + 1);
        check_eq("t4b_err", bus.err_o, 0);
        check_eq("t4b_code", bus.err_code_o, 0);
        tr0_i = 1'b0;
        repeat (4) @(negedge clk);

        // Seek beyond track 127
        base = n_rise;
        issue_seek(8'd200);
        check_eq("t5_busy", bus.busy_o, 1);
        wait_done(10);
        check_eq("t5_done_lat", dcyc - acc, 1);
        check_eq("t5_pulses", n_rise - base, 0);
        check_eq("t5_err", bus.err_o, 1);
        check_eq("t5_code", bus.err_code_o, 7'o10);
        check_eq("t5_track", bus.cur_track_o, 0);

        // Seek to the current track
        issue_seek(8'd0);
        wait_done(10);
        check_eq("t5b_done_lat", dcyc - acc, 1);
        check_eq("t5b_pulses", n_rise - base, 0);
        check_eq("t5b_err", bus.err_o, 0);
        check_eq("t5b_code", bus.err_code_o, 0);

        // Reset asserted during a step pulse
        issue_seek(8'd5);
        dcyc = -1;
        for (int i = 0; i < 50; i++) begin
            if (step_o) begin
                dcyc = cyc;
                break;
            end
            @(negedge clk);
        end
        check_eq("t6_step_seen", (dcyc >= 0), 1);
        #1 init_n = 1'b0;
        #1;
        check_eq("t6_step_async", step_o, 0);
        check_eq("t6_dir",   dir_o, 0);
        check_eq("t6_busy",  bus.busy_o, 0);
        check_eq("t6_done",  bus.done_o, 0);
        check_eq("t6_err",   bus.err_o, 0);
        check_eq("t6_code",  bus.err_code_o, 0);
        check_eq("t6_track", bus.cur_track_o, 0);
        base = n_rise;
        @(negedge clk);
        init_n = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("t6_no_pulses_after_rst", n_rise - base, 0);
        check_eq("t6_idle", bus.busy_o, 0);

        // Command while busy is ignored
        base = n_rise;
        issue_seek(8'd2);
        for (int i = 0; i < 50 && n_rise == base; i++) @(negedge clk);
        issue_seek(8'd7);
        wait_done(300);
        check_eq("t7_pulses", n_rise - base, 2);
        check_eq("t7_track", bus.cur_track_o, 2);
        check_eq("t7_err", bus.err_o, 0);
        repeat (30) @(negedge clk);
        check_eq("t7_no_restart", n_rise - base, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fdd_seek_ctrl.md
Name: fdd_seek_ctrl

Overview:
- Head-positioning sequencer for the UKNC floppy subsystem; replaces CPU-timed 177130 step writes with a hardware seek/recalibrate engine.
- Accepts seek or recalibrate commands from the PPU register decoder, generates timed step/dir pulses to the drive, tracks the current cylinder and reports completion.
- Error codes match the ROM driver codes: 7 = track 0 not found, 10 (octal) = track >= 128.

Parameters:
- STEP_W, 8, clock cycles step_o is held high (320 ns at 25 MHz).
- STEP_RATE, 75000, cycles from one step rising edge to the next (3 ms).
- DIR_SETUP, 25, cycles dir_o is stable before the first step rising edge.
- SETTLE, 375000, head settle cycles after the last step (15 ms).
- MAX_RECAL, 84, steps toward track 0 before recalibrate fails.
- CNT_W, 20, width of the shared timing counter.

Ports:
- clk_25  in  1  system clock, 25 MHz.
- init_n  in  1  asynchronous active-low reset.
- cmd_seek  in  1  single-cycle pulse: seek to target_i.
- cmd_recal  in  1  single-cycle pulse: step out until tr0, then cur_track = 0.
- target_i  in  8  seek target cylinder.
- tr0_i  in  1  drive track-0 sensor, asynchronous, active-high.
- step_o  out  1  drive step pulse.
- dir_o  out  1  1 = inward (track+1), 0 = outward (track-1).
- busy_o  out  1  high while any command is active.
- done_o  out  1  one-cycle pulse at command end, success or error.
- err_o  out  1  sticky error flag, valid from done_o.
- err_code_o  out  7  0, 7'o7 or 7'o10.
- cur_track_o  out  8  current cylinder.

Behaviour:
- Reset (init_n low, async): state IDLE, step_o = 0, dir_o = 0, busy_o = 0, done_o = 0, err_o = 0, err_code_o = 0, cur_track_o = 0, counter = 0, tr0 synchroniser cleared. Reset mid-step drops step_o immediately; no further pulses are issued.
- tr0_i passes through a 2-flop synchroniser. All use of tr0 is 2 cycles late.
- A command is accepted only in IDLE. Commands arriving while busy_o = 1 are ignored. If cmd_seek and cmd_recal arrive in the same cycle, recal wins.
- Acceptance clears err_o and err_code_o and sets busy_o on the next edge.
- Seek with target_i >= 128: no steps are issued. The block goes to DONE with err_o = 1 and err_code_o = 7'o10 (busy_o high for 1 cycle).
- Seek with target_i == cur_track_o: goes straight to SETTLE-free DONE (done_o 2 cycles after cmd), no error.
- Otherwise dir_o = (target_i > cur_track_o), then the state machine runs:
  - DIRSET: wait DIR_SETUP cycles.
  - STEP_HI: step_o = 1 for STEP_W cycles.
  - STEP_LO: step_o = 0 until STEP_RATE cycles have elapsed since the rising edge.
- cur_track_o changes by ±1 on each step rising edge. After a step, if cur_track_o == target_i, go to SETTLE; otherwise go to STEP_HI at the end of STEP_LO.
- Recal: dir_o = 0, then the same DIRSET, STEP_HI and STEP_LO cycle. Before each step, synchronised tr0 is checked.
  - If tr0 is high: cur_track_o = 0, go to SETTLE. If tr0 is already high at acceptance, zero steps are issued.
  - Step counter reaching MAX_RECAL without tr0: cur_track_o = 0, err_o = 1, err_code_o = 7'o7, go to DONE (no settle).
- cur_track_o saturates at 0 on outward steps during recal.
- SETTLE: wait SETTLE cycles, then go to DONE.
- DONE: done_o = 1 for one cycle, busy_o falls in the same cycle, return to IDLE.
- Counter is CNT_W bits and reloads on every state entry. Parameters must be < 2^CNT_W; this is checked by a static assertion.

Decomposition:
- Package fdd_pkg holds:
  - state enum (IDLE, DIRSET, STEP_HI, STEP_LO, SETTLE, DONE);
  - error code constants ERR_TR0 = 7'o7 and ERR_TRK = 7'o10, shared with the future read/write controller.
- The only natural sub-module is sync2, the 2-flop tr0 synchroniser. Everything else stays in one FSM.

Test Plan (small parameters: STEP_W = 2, STEP_RATE = 10, DIR_SETUP = 3, SETTLE = 20, MAX_RECAL = 5):
- Reset, then cmd_seek with target 3 from track 0 -> dir_o = 1, exactly 3 step pulses 2 cycles wide and 10 cycles apart, first rise 3 cycles after DIRSET entry. cur_track 0→1→2→3, done_o 20 cycles after the last step, err_o = 0.
- Then cmd_seek with target 1 -> dir_o = 0, 2 pulses, cur_track_o = 1, no error.
- cmd_recal with tr0_i rising after the 2nd step -> 2 steps (3rd pulse suppressed), cur_track_o = 0, err_o = 0.
- cmd_recal with tr0_i held low -> exactly 5 pulses, done_o without settle, err_o = 1, err_code_o = 7'o7, cur_track_o = 0.
- cmd_seek with target 200 -> no step pulses, err_code_o = 7'o10, done_o within 2 cycles. Repeating with target == cur_track_o gives done_o with no error.
- init_n low during STEP_HI -> step_o = 0 asynchronously and all outputs at reset values. A cmd_seek pulse issued while busy_o = 1 produces no extra steps.
